wfg_wishbone_master: RTL and testbench
======================================

// Module: wfg_wishbone_master
//
// PURPOSE
// - Wishbone classic single-transfer initiator.
// - Drives register writes/reads into the wfg_*_wishbone_reg slaves, e.g. for sequencers or bring-up.
// - Internal side: valid/ready command in, valid/ready response out.
// - One transaction outstanding at a time; ack timeout reports an error instead of hanging.
//
// PARAMETERS
// - BUSW     32  data/address width; select width is BUSW/8.
// - TIMEOUT  16  max cycles CYC/STB stay asserted without ack (>=2).
//
// PORTS
// - wb_clk_i      in   1        single clock; all logic on the rising edge.
// - wb_rst_ni     in   1        reset, synchronous, active-low.
// - cmd_valid_i   in   1        command request.
// - cmd_ready_o   out  1        command accepted when valid&ready.
// - cmd_we_i      in   1        1 = write, 0 = read.
// - cmd_adr_i     in   BUSW     byte address.
// - cmd_dat_i     in   BUSW     write data (ignored on reads).
// - cmd_sel_i     in   BUSW/8   byte selects.
// - rsp_valid_o   out  1        response available.
// - rsp_ready_i   in   1        response consumed when valid&ready.
// - rsp_dat_o     out  BUSW     read data; 0 for writes and on error.
// - rsp_err_o     out  1        1 = timeout, no ack received.
// - wbm_cyc_o     out  1        bus cycle.
// - wbm_stb_o     out  1        strobe (always equal to wbm_cyc_o).
// - wbm_we_o      out  1        write enable.
// - wbm_sel_o     out  BUSW/8   byte selects.
// - wbm_adr_o     out  BUSW     address.
// - wbm_dat_o     out  BUSW     write data; 0 during reads.
// - wbm_ack_i     in   1        slave acknowledge.
// - wbm_dat_i     in   BUSW     slave read data; valid in the ack cycle.
//
// BEHAVIOUR
// - All outputs registered, except cmd_ready_o = (state==IDLE).
// - Reset (wb_rst_ni=0 at an edge): state IDLE; every registered output 0; timeout counter 0.
//   - Mid-transaction reset abandons the transfer.
//   - CYC/STB low from the next edge; no response is issued.
// - FSM IDLE -> BUS -> RSP -> IDLE:
//   - IDLE: on cmd_valid_i&cmd_ready_o, latch we/adr/dat/sel.
//     - Assert CYC/STB; clear counter; go to BUS.
//     - For reads, wbm_dat_o is 0.
//   - BUS: hold all wbm_* stable; counter increments each cycle.
//     - ack_i=1 at an edge:
//       - CYC/STB low at that edge (never held into the cycle after ack).
//       - rsp_dat_o = we ? 0 : wbm_dat_i; rsp_err_o = 0; go to RSP.
//     - Counter == TIMEOUT-1 with no ack: CYC/STB low, rsp_err_o = 1, rsp_dat_o = 0; go to RSP.
//       CYC is high for exactly TIMEOUT cycles.
//     - Ack and timeout at the same edge: ack wins, err = 0.
//   - RSP: rsp_valid_o = 1; rsp_dat_o/rsp_err_o held stable until rsp_ready_i.
//     - On handshake: rsp_valid_o = 0; go to IDLE.
//     - cmd_ready_o stays 0 until then.
// - wbm_ack_i outside BUS is ignored (late/stray ack).
// - Latency with a 1-cycle-ack slave:
//   - Command accepted at edge N; CYC high N..N+2; ack sampled at edge N+2.
//   - rsp_valid_o high from edge N+2.
//   - Next command accepted no earlier than the edge after the response handshake.
// - Address is passed unchanged; no alignment check.
// - Counter width is $clog2(TIMEOUT)+1; it never wraps.
//
// STRUCTURE
// - Package wfg_wb_pkg:
//   - state enum {IDLE, BUS, RSP} (2-bit).
//   - WB_BUSW_DEFAULT = 32.
//   - Request/response packed structs, shared with future sequencers.
// - Single module, no sub-module. FSM, timeout counter and capture registers fit in one file.
//
// TESTING
// - Write against wfg_drive_pat_wishbone_reg: adr 0x4, dat 0x0001_0A05, sel 0xF.
//   -> cfg_begin_q_o = 0x05, cfg_end_q_o = 0x0A, cfg_core_sel_q_o = 1.
//   -> exactly one ack pulse; rsp_err_o = 0; rsp_dat_o = 0.
// - Read adr 0x4 after the write above.
//   -> rsp_dat_o = 0x0001_0A05, rsp_err_o = 0, rsp_valid_o at command edge + 2.
// - Stub slave that never acks, TIMEOUT = 16.
//   -> CYC/STB high exactly 16 cycles; rsp_err_o = 1; rsp_dat_o = 0.
// - rsp_ready_i low for 5 cycles after a read of 0xC (patsel1 = 0xDEAD_BEEF).
//   -> rsp_valid_o, rsp_dat_o stable for all 5 cycles; cmd_ready_o = 0 throughout.
// - Reset pulsed while in BUS, with a late ack 1 cycle after reset.
//   -> CYC/STB/rsp_valid_o = 0 after the edge; ack ignored; no response.
// - 4 back-to-back writes to 0x0/0x4/0x8/0xC, cmd_valid_i and rsp_ready_i held 1.
//   -> exactly 4 ack pulses; no double access; all four slave registers hold the written data.

Source files
------------

// File: rtl/wfg_wb_pkg.sv
// Shared Wishbone initiator types: FSM state encoding and request/response
// records that sequencers use to talk to wfg_wishbone_master.
package wfg_wb_pkg;

  localparam int WB_BUSW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                           we;
    logic [WB_BUSW_DEFAULT-1:0]     adr;
    logic [WB_BUSW_DEFAULT-1:0]     dat;
    logic [WB_BUSW_DEFAULT/8-1:0]   sel;
  } wb_req_t;

  typedef struct packed {
    logic [WB_BUSW_DEFAULT-1:0]     dat;
    logic                           err;
  } wb_rsp_t;

endpackage

// File: rtl/wfg_wishbone_master.sv
// Wishbone classic single-transfer initiator: one command in flight, valid/ready
// on both internal sides, and a bounded wait for ack that reports a timeout error.
module wfg_wishbone_master
  import wfg_wb_pkg::*;
#(
  parameter int BUSW    = WB_BUSW_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [BUSW-1:0]   cmd_adr_i,
  input  logic [BUSW-1:0]   cmd_dat_i,
  input  logic [BUSW/8-1:0] cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BUSW-1:0]   rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BUSW/8-1:0] wbm_sel_o,
  output logic [BUSW-1:0]   wbm_adr_o,
  output logic [BUSW-1:0]   wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [BUSW-1:0]   wbm_dat_i
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  wb_state_e         r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_cyc;
  logic              r_we;
  logic [BUSW/8-1:0] r_sel;
  logic [BUSW-1:0]   r_adr;
  logic [BUSW-1:0]   r_dat;
  logic              r_rsp_valid;
  logic [BUSW-1:0]   r_rsp_dat;
  logic              r_rsp_err;

  logic w_accept;
  logic w_timeout;

  assign w_accept  = cmd_valid_i && (r_state == IDLE);
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = BUS;
      BUS:     if (wbm_ack_i || w_timeout) w_state_nxt = RSP;
      RSP:     if (rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (w_accept) begin
          r_cyc <= 1'b1;
          r_we  <= cmd_we_i;
          r_adr <= cmd_adr_i;
          r_sel <= cmd_sel_i;
          r_dat <= cmd_we_i ? cmd_dat_i : '0;
          r_cnt <= '0;
        end
        // Ack takes priority over a timeout landing on the same edge.
        BUS: if (wbm_ack_i) begin
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
          r_rsp_err   <= 1'b0;
        end else if (w_timeout) begin
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_dat   <= '0;
          r_rsp_err   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        RSP: if (rsp_ready_i) r_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign cmd_ready_o = (r_state == IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;

endmodule

// File: tb/tb_wfg_wishbone_master.sv
// Bench for wfg_wishbone_master: small register slave model (4 words at 0x0..0xC),
// expected responses queued at command acceptance and checked at the response handshake.
module tb_wfg_wishbone_master;
  import wfg_wb_pkg::*;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  int tests = 0;
  int fails = 0;
  int ack_pulses = 0;
  int stb_err = 0;
  wb_rsp_t sb_q[$];

  // slave model
  logic        slv_ack = 1'b0;
  logic        slv_mute = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] slv_regs [4];

  assign wbm_ack_i = slv_ack | stray_ack;
  assign wbm_dat_i = slv_regs[wbm_adr_o[3:2]];

  always @(posedge wb_clk_i) begin
    if (!wb_rst_ni) slv_ack <= 1'b0;
    else begin
      slv_ack <= wbm_cyc_o && wbm_stb_o && !slv_ack && !slv_mute;
      if (wbm_cyc_o && wbm_stb_o && !slv_ack && !slv_mute && wbm_we_o)
        for (int b = 0; b < 4; b++)
          if (wbm_sel_o[b]) slv_regs[wbm_adr_o[3:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
    end
  end

  always #5 wb_clk_i = ~wb_clk_i;

  wfg_wishbone_master #(.BUSW(32), .TIMEOUT(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  initial forever begin
    @(posedge wb_clk_i);
    if (wbm_ack_i) ack_pulses++;
  end

  initial forever begin
    @(negedge wb_clk_i);
    if (wbm_stb_o !== wbm_cyc_o) stb_err++;
  end

  // scoreboard: pop at each response handshake
  initial forever begin
    @(negedge wb_clk_i);
    if (wb_rst_ni && rsp_valid_o && rsp_ready_i) begin
      wb_rsp_t e;
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got dat=%h err=%b, expected no response", rsp_dat_o, rsp_err_o);
      end else begin
        e = sb_q.pop_front();
        if (rsp_dat_o !== e.dat) begin
          fails++;
          $display("FAIL sb_dat: got %h, expected %h", rsp_dat_o, e.dat);
        end
        tests++;
        if (rsp_err_o !== e.err) begin
          fails++;
          $display("FAIL sb_err: got %b, expected %b", rsp_err_o, e.err);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] edat, input logic eerr,
                       input logic hold);
    int n = 0;
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel; cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 200) begin
      @(posedge wb_clk_i); #1; n++;
    end
    if (!cmd_ready_o) begin
      tests++; fails++;
      $display("FAIL accept_timeout: cmd_ready_o=%b after %0d cycles, expected 1", cmd_ready_o, n);
      cmd_valid_i = 1'b0;
      return;
    end
    @(posedge wb_clk_i);
    sb_q.push_back('{dat: edat, err: eerr});
    #1;
    if (!hold) cmd_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || rsp_valid_o) && n < 100) begin
      @(posedge wb_clk_i); #1; n++;
    end
    tests++;
    if (sb_q.size() != 0 || rsp_valid_o) begin
      fails++;
      $display("FAIL drain: %0d responses pending, rsp_valid_o=%b, expected 0/0", sb_q.size(), rsp_valid_o);
    end
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    tests++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid_o, rsp_err_o} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctl: cyc/stb/we/rvalid/err=%b, expected 00000",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid_o, rsp_err_o});
    end
    tests++;
    if ({wbm_adr_o, wbm_dat_o, rsp_dat_o, wbm_sel_o} !== '0) begin
      fails++;
      $display("FAIL reset_data: adr=%h dat=%h rdat=%h sel=%h, expected all 0",
               wbm_adr_o, wbm_dat_o, rsp_dat_o, wbm_sel_o);
    end
    tests++;
    if (cmd_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: cmd_ready_o=%b, expected 1", cmd_ready_o);
    end
    wb_rst_ni = 1'b1;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_write();
    ack_pulses = 0;
    issue(1'b1, 32'h4, 32'h0001_0A05, 4'hF, 32'h0, 1'b0, 1'b0);
    tests++;
    if (wbm_dat_o !== 32'h0001_0A05 || wbm_we_o !== 1'b1) begin
      fails++;
      $display("FAIL wr_bus: dat=%h we=%b, expected 00010a05/1", wbm_dat_o, wbm_we_o);
    end
    wait_drain();
    repeat (2) @(posedge wb_clk_i);
    #1;
    tests++;
    if (ack_pulses != 1) begin
      fails++;
      $display("FAIL wr_acks: got %0d ack pulses, expected 1", ack_pulses);
    end
    tests++;
    if (slv_regs[1][7:0] !== 8'h05 || slv_regs[1][15:8] !== 8'h0A || slv_regs[1][16] !== 1'b1) begin
      fails++;
      $display("FAIL wr_cfg: begin=%h end=%h core_sel=%b, expected 05/0a/1",
               slv_regs[1][7:0], slv_regs[1][15:8], slv_regs[1][16]);
    end
  endtask

  task automatic test_read();
    issue(1'b0, 32'h4, 32'hFFFF_FFFF, 4'hF, 32'h0001_0A05, 1'b0, 1'b0);
    tests++;
    if (wbm_dat_o !== 32'h0 || wbm_cyc_o !== 1'b1) begin
      fails++;
      $display("FAIL rd_bus: dat=%h cyc=%b, expected 0/1", wbm_dat_o, wbm_cyc_o);
    end
    @(posedge wb_clk_i); #1;
    tests++;
    if (rsp_valid_o !== 1'b0 || wbm_cyc_o !== 1'b1) begin
      fails++;
      $display("FAIL rd_lat1: rvalid=%b cyc=%b at N+1, expected 0/1", rsp_valid_o, wbm_cyc_o);
    end
    @(posedge wb_clk_i); #1;
    tests++;
    if (rsp_valid_o !== 1'b1 || wbm_cyc_o !== 1'b0) begin
      fails++;
      $display("FAIL rd_lat2: rvalid=%b cyc=%b at N+2, expected 1/0", rsp_valid_o, wbm_cyc_o);
    end
    wait_drain();
  endtask

  task automatic test_timeout();
    int n = 0;
    slv_mute = 1'b1;
    issue(1'b0, 32'h8, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0);
    while (wbm_cyc_o && n < 100) begin
      @(posedge wb_clk_i); #1; n++;
    end
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL to_len: cyc high %0d cycles, expected 16", n);
    end
    wait_drain();
    slv_mute = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    d[0] = 32'h1111_2222; d[1] = 32'h0001_0A05; d[2] = 32'h3C3C_5A5A; d[3] = 32'hDEAD_BEEF;
    ack_pulses = 0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++)
      issue(1'b1, 32'(i * 4), d[i], 4'hF, 32'h0, 1'b0, 1'b1);
    cmd_valid_i = 1'b0;
    wait_drain();
    repeat (2) @(posedge wb_clk_i);
    #1;
    tests++;
    if (ack_pulses != 4) begin
      fails++;
      $display("FAIL b2b_acks: got %0d ack pulses, expected 4", ack_pulses);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (slv_regs[i] !== d[i]) begin
        fails++;
        $display("FAIL b2b_reg%0d: got %h, expected %h", i, slv_regs[i], d[i]);
      end
    end
    tests++;
    if (stb_err != 0) begin
      fails++;
      $display("FAIL stb_eq_cyc: %0d cycles with stb != cyc, expected 0", stb_err);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    rsp_ready_i = 1'b0;
    issue(1'b0, 32'hC, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cmd_valid_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    for (int i = 0; i < 5; i++) begin
      @(posedge wb_clk_i); #1;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'hDEAD_BEEF || cmd_ready_o !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_hold: %0d of 5 cycles unstable (rvalid=%b dat=%h rdy=%b), expected 0",
               bad, rsp_valid_o, rsp_dat_o, cmd_ready_o);
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_in_bus();
    int bad = 0;
    slv_mute = 1'b1;
    issue(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1, 1'b0);
    @(posedge wb_clk_i); #1;
    wb_rst_ni = 1'b0;
    sb_q.delete();
    @(posedge wb_clk_i); #1;
    tests++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_bus: cyc=%b stb=%b rvalid=%b, expected 000", wbm_cyc_o, wbm_stb_o, rsp_valid_o);
    end
    wb_rst_ni = 1'b1;
    stray_ack = 1'b1;
    @(posedge wb_clk_i); #1;
    stray_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid_o !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready_o !== 1'b1) bad++;
      @(posedge wb_clk_i); #1;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rst_stray_ack: %0d bad cycles (rvalid=%b cyc=%b rdy=%b), expected 0",
               bad, rsp_valid_o, wbm_cyc_o, cmd_ready_o);
    end
    slv_mute = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_stall();
    test_reset_in_bus();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
